// File: rtl/wb32_arbiter2_if.sv
// Wishbone B4 pipelined bus bundle for the two-master arbiter: both master ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb32_arbiter2_if;
    logic        m0_cyc;
    logic        m0_stb;
    logic        m0_we;
    logic [29:0] m0_adr;
    logic [3:0]  m0_sel;
    logic [31:0] m0_wdat;
    logic [31:0] m0_rdat;
    logic        m0_ack;
    logic        m0_stall;
    logic        m0_err;

    logic        m1_cyc;
    logic        m1_stb;
    logic        m1_we;
    logic [29:0] m1_adr;
    logic [3:0]  m1_sel;
    logic [31:0] m1_wdat;
    logic [31:0] m1_rdat;
    logic        m1_ack;
    logic        m1_stall;
    logic        m1_err;

    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [29:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_wdat;
    logic [31:0] s_rdat;
    logic        s_ack;
    logic        s_stall;

    logic [1:0]  grant;

    modport slave (
        input  m0_cyc, m0_stb, m0_we, m0_adr, m0_sel, m0_wdat,
        input  m1_cyc, m1_stb, m1_we, m1_adr, m1_sel, m1_wdat,
        input  s_rdat, s_ack, s_stall,
        output m0_rdat, m0_ack, m0_stall, m0_err,
        output m1_rdat, m1_ack, m1_stall, m1_err,
        output s_cyc, s_stb, s_we, s_adr, s_sel, s_wdat,
        output grant
    );

    modport master (
        output m0_cyc, m0_stb, m0_we, m0_adr, m0_sel, m0_wdat,
        output m1_cyc, m1_stb, m1_we, m1_adr, m1_sel, m1_wdat,
        output s_rdat, s_ack, s_stall,
        input  m0_rdat, m0_ack, m0_stall, m0_err,
        input  m1_rdat, m1_ack, m1_stall, m1_err,
        input  s_cyc, s_stb, s_we, s_adr, s_sel, s_wdat,
        input  grant
    );
endinterface

// File: rtl/wb32_arbiter2.sv
// Round-robin two-master Wishbone arbiter, grant held per cyc, one-cycle arbitration latency, zero-latency pass-through.
// Non-owner is stalled; owner sees slave stall; a watchdog aborts un-acked cycles with a one-cycle err pulse.
module wb32_arbiter2 #(
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          RESET_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    wb32_arbiter2_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OWN0  = 3'd1,
        OWN1  = 3'd2,
        ABORT = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam bit        WD_EN    = (TIMEOUT != 0);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last_served, last_served_nxt;
    logic        owner, owner_nxt;
    logic [15:0] wd, wd_nxt;

    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [29:0] own_adr;
    logic [3:0]  own_sel;
    logic [31:0] own_wdat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= RESET_LAST;
            owner       <= 1'b0;
            wd          <= '0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            owner       <= owner_nxt;
            wd          <= wd_nxt;
        end
    end

    always_comb begin
        own_cyc  = owner ? bus.m1_cyc  : bus.m0_cyc;
        own_stb  = owner ? bus.m1_stb  : bus.m0_stb;
        own_we   = owner ? bus.m1_we   : bus.m0_we;
        own_adr  = owner ? bus.m1_adr  : bus.m0_adr;
        own_sel  = owner ? bus.m1_sel  : bus.m0_sel;
        own_wdat = owner ? bus.m1_wdat : bus.m0_wdat;
    end

    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        owner_nxt       = owner;
        wd_nxt          = wd;

        bus.s_cyc    = 1'b0;
        bus.s_stb    = 1'b0;
        bus.s_we     = 1'b0;
        bus.s_adr    = '0;
        bus.s_sel    = '0;
        bus.s_wdat   = '0;
        bus.m0_rdat  = '0;
        bus.m0_ack   = 1'b0;
        bus.m0_stall = 1'b1;
        bus.m0_err   = 1'b0;
        bus.m1_rdat  = '0;
        bus.m1_ack   = 1'b0;
        bus.m1_stall = 1'b1;
        bus.m1_err   = 1'b0;
        bus.grant    = 2'b00;

        unique case (state)
            IDLE: begin
                wd_nxt = '0;
                if (bus.m0_cyc && bus.m1_cyc) begin
                    owner_nxt = ~last_served;
                    state_nxt = last_served ? OWN0 : OWN1;
                end else if (bus.m0_cyc) begin
                    owner_nxt = 1'b0;
                    state_nxt = OWN0;
                end else if (bus.m1_cyc) begin
                    owner_nxt = 1'b1;
                    state_nxt = OWN1;
                end
            end

            OWN0, OWN1: begin
                bus.grant  = owner ? 2'b10 : 2'b01;
                bus.s_cyc  = own_cyc;
                bus.s_stb  = own_stb;
                bus.s_we   = own_we;
                bus.s_adr  = own_adr;
                bus.s_sel  = own_sel;
                bus.s_wdat = own_wdat;
                if (owner) begin
                    bus.m1_rdat  = bus.s_rdat;
                    bus.m1_ack   = bus.s_ack;
                    bus.m1_stall = bus.s_stall;
                end else begin
                    bus.m0_rdat  = bus.s_rdat;
                    bus.m0_ack   = bus.s_ack;
                    bus.m0_stall = bus.s_stall;
                end
                // Release takes priority over the watchdog; an ack in the limit cycle also wins.
                if (!own_cyc) begin
                    state_nxt       = IDLE;
                    last_served_nxt = owner;
                end else if (bus.s_ack) begin
                    wd_nxt = '0;
                end else if (WD_EN && (wd == WD_LIMIT)) begin
                    state_nxt = ABORT;
                end else begin
                    wd_nxt = wd + 16'd1;
                end
            end

            ABORT: begin
                bus.grant = owner ? 2'b10 : 2'b01;
                if (owner) begin
                    bus.m1_err = 1'b1;
                end else begin
                    bus.m0_err = 1'b1;
                end
                state_nxt = DRAIN;
            end

            DRAIN: begin
                bus.grant = owner ? 2'b10 : 2'b01;
                if (!own_cyc) begin
                    state_nxt       = IDLE;
                    last_served_nxt = owner;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb32_arbiter2.sv
// Bench for wb32_arbiter2 (TIMEOUT=8): directed scenarios followed by randomized traffic against a reference model.
module tb_wb32_arbiter2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    wb32_arbiter2_if bus();

    wb32_arbiter2 #(.TIMEOUT(TO), .RESET_LAST(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_cyc = 0; bus.m0_stb = 0; bus.m0_we = 0; bus.m0_adr = '0; bus.m0_sel = '0; bus.m0_wdat = '0;
        bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0; bus.m1_adr = '0; bus.m1_sel = '0; bus.m1_wdat = '0;
        bus.s_rdat = '0; bus.s_ack = 0; bus.s_stall = 0;
    endtask

    task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic we,
                           input logic [29:0] adr, input logic [31:0] wdat);
        if (idx == 0) begin
            bus.m0_cyc = cyc; bus.m0_stb = stb; bus.m0_we = we; bus.m0_adr = adr; bus.m0_sel = 4'hF; bus.m0_wdat = wdat;
        end else begin
            bus.m1_cyc = cyc; bus.m1_stb = stb; bus.m1_we = we; bus.m1_adr = adr; bus.m1_sel = 4'hF; bus.m1_wdat = wdat;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++; if (bus.s_cyc !== 1'b0)   begin failures++; $display("FAIL reset_s_cyc got %b want 0", bus.s_cyc); end
        checks++; if (bus.s_adr !== 30'd0)  begin failures++; $display("FAIL reset_s_adr got %h want 0", bus.s_adr); end
        checks++; if (bus.grant !== 2'b00)  begin failures++; $display("FAIL reset_grant got %b want 00", bus.grant); end
        checks++; if ({bus.m0_stall, bus.m1_stall} !== 2'b11) begin failures++; $display("FAIL reset_stalls got %b want 11", {bus.m0_stall, bus.m1_stall}); end
        checks++; if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 4'b0000) begin failures++; $display("FAIL reset_ack_err got %b want 0000", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}); end
    endtask

    task automatic test_arbitration();
        reset_n = 1'b1;
        drive_m(0, 1, 1, 0, 30'h0000_0100, 32'h0);
        drive_m(1, 1, 1, 0, 30'h0000_0200, 32'h0);
        #1;
        checks++; if (bus.grant !== 2'b00)   begin failures++; $display("FAIL arb_first_cycle_grant got %b want 00", bus.grant); end
        checks++; if (bus.m0_stall !== 1'b1) begin failures++; $display("FAIL arb_first_cycle_stall got %b want 1", bus.m0_stall); end
        next_cycle();
        checks++; if (bus.grant !== 2'b01)   begin failures++; $display("FAIL arb_grant_m0 got %b want 01", bus.grant); end
        checks++; if (bus.m1_stall !== 1'b1) begin failures++; $display("FAIL arb_m1_stalled got %b want 1", bus.m1_stall); end
        checks++; if (bus.s_adr !== 30'h100) begin failures++; $display("FAIL arb_s_adr_m0 got %h want 100", bus.s_adr); end
        drive_m(0, 0, 0, 0, 30'h0, 32'h0);
        #1;
        checks++; if (bus.s_cyc !== 1'b0)    begin failures++; $display("FAIL arb_s_cyc_drop got %b want 0", bus.s_cyc); end
        next_cycle();
        checks++; if (bus.grant !== 2'b00)   begin failures++; $display("FAIL arb_gap_grant got %b want 00", bus.grant); end
        next_cycle();
        checks++; if (bus.grant !== 2'b10)   begin failures++; $display("FAIL arb_grant_m1 got %b want 10", bus.grant); end
        checks++; if (bus.s_adr !== 30'h200) begin failures++; $display("FAIL arb_s_adr_m1 got %h want 200", bus.s_adr); end
        drive_m(1, 0, 0, 0, 30'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_read_stall();
        drive_m(1, 1, 1, 0, 30'h0000_0055, 32'h0);
        drive_m(0, 1, 1, 0, 30'h3FFF_FC00, 32'h0);
        bus.s_stall = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.s_adr !== 30'h3FFF_FC00) begin failures++; $display("FAIL read_s_adr got %h want 3ffffc00", bus.s_adr); end
            checks++; if ({bus.m0_stall, bus.m0_ack, bus.m1_ack} !== 3'b100) begin failures++; $display("FAIL read_stalled got %b want 100", {bus.m0_stall, bus.m0_ack, bus.m1_ack}); end
            next_cycle();
        end
        bus.s_stall = 1'b0;
        #1;
        checks++; if (bus.m0_stall !== 1'b0) begin failures++; $display("FAIL read_stall_release got %b want 0", bus.m0_stall); end
        next_cycle();
        bus.m0_stb = 1'b0;
        bus.s_ack  = 1'b1;
        bus.s_rdat = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.m0_ack !== 1'b1) begin failures++; $display("FAIL read_m0_ack got %b want 1", bus.m0_ack); end
        checks++; if (bus.m0_rdat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_m0_dat got %h want deadbeef", bus.m0_rdat); end
        checks++; if ({bus.m1_ack, bus.m1_rdat} !== 33'd0) begin failures++; $display("FAIL read_m1_quiet got %h want 0", {bus.m1_ack, bus.m1_rdat}); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_burst();
        int acks = 0;
        drive_m(0, 1, 0, 1, 30'h0, 32'h0);
        next_cycle();
        drive_m(1, 1, 1, 0, 30'h0000_0077, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bus.m0_stb  = (i < 4);
            bus.m0_adr  = 30'(i);
            bus.m0_wdat = 32'(i * 16'h1111);
            bus.s_ack   = (i >= 1 && i <= 4);
            #1;
            if (bus.m0_ack) acks++;
            checks++; if (bus.grant !== 2'b01)   begin failures++; $display("FAIL burst_grant beat=%0d got %b want 01", i, bus.grant); end
            checks++; if (bus.m1_stall !== 1'b1) begin failures++; $display("FAIL burst_m1_stall beat=%0d got %b want 1", i, bus.m1_stall); end
            next_cycle();
        end
        bus.s_ack = 1'b0;
        checks++; if (acks != 4) begin failures++; $display("FAIL burst_acks got %0d want 4", acks); end
        drive_m(0, 0, 0, 0, 30'h0, 32'h0);
        next_cycle();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL burst_gap got %b want 00", bus.grant); end
        next_cycle();
        checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL burst_handover got %b want 10", bus.grant); end
        drive_m(1, 0, 0, 0, 30'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_timeout();
        int errs = 0;
        drive_m(1, 1, 1, 1, 30'h0000_1234, 32'hCAFE_F00D);
        next_cycle();
        for (int i = 1; i <= TO; i++) begin
            if (bus.m1_err) errs++;
            checks++; if ({bus.grant, bus.s_cyc, bus.s_we} !== 4'b1011) begin failures++; $display("FAIL to_owned cyc=%0d got %b want 1011", i, {bus.grant, bus.s_cyc, bus.s_we}); end
            next_cycle();
        end
        bus.s_ack = 1'b1;
        #1;
        if (bus.m1_err) errs++;
        checks++; if (bus.m1_err !== 1'b1) begin failures++; $display("FAIL to_err_pulse got %b want 1", bus.m1_err); end
        checks++; if ({bus.s_cyc, bus.m1_ack, bus.m1_stall} !== 3'b001) begin failures++; $display("FAIL to_abort_outputs got %b want 001", {bus.s_cyc, bus.m1_ack, bus.m1_stall}); end
        next_cycle();
        if (bus.m1_err) errs++;
        checks++; if ({bus.s_cyc, bus.m1_ack, bus.grant} !== 4'b0010) begin failures++; $display("FAIL to_drain got %b want 0010", {bus.s_cyc, bus.m1_ack, bus.grant}); end
        bus.s_ack = 1'b0;
        drive_m(1, 0, 0, 0, 30'h0, 32'h0);
        next_cycle();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL to_release got %b want 00", bus.grant); end
        checks++; if (errs != 1) begin failures++; $display("FAIL to_err_count got %0d want 1", errs); end
    endtask

    task automatic test_ack_at_limit();
        drive_m(1, 1, 1, 0, 30'h0000_0042, 32'h0);
        next_cycle();
        for (int i = 1; i <= 2 * TO + 1; i++) begin
            bus.s_ack  = (i % TO == 0) && (i <= 2 * TO);
            bus.s_rdat = 32'(i);
            #1;
            checks++; if (bus.m1_err !== 1'b0) begin failures++; $display("FAIL limit_no_err cyc=%0d got %b want 0", i, bus.m1_err); end
            if (bus.s_ack) begin
                checks++; if ({bus.m1_ack, bus.m1_rdat} !== {1'b1, 32'(i)}) begin failures++; $display("FAIL limit_ack cyc=%0d got %h want %h", i, {bus.m1_ack, bus.m1_rdat}, {1'b1, 32'(i)}); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive_m(1, 1, 1, 1, 30'h0000_0300, 32'h1357_9BDF);
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        drive_m(0, 1, 1, 0, 30'h0000_0400, 32'h0);
        bus.s_ack = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        #1;
        checks++; if ({bus.s_cyc, bus.grant} !== 3'b000) begin failures++; $display("FAIL rmid_idle got %b want 000", {bus.s_cyc, bus.grant}); end
        checks++; if ({bus.m0_stall, bus.m1_stall, bus.m1_ack} !== 3'b110) begin failures++; $display("FAIL rmid_stalls got %b want 110", {bus.m0_stall, bus.m1_stall, bus.m1_ack}); end
        bus.s_ack = 1'b0;
        next_cycle();
        checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL rmid_m0_first got %b want 01", bus.grant); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int owner = -1;
        int last = 1;
        int quiet = 0;
        bit dead = 0;
        bit err_now = 0;
        bit mc[2];
        logic [29:0] madr[2];
        logic [31:0] mwd[2];
        logic        mst[2], mwe[2];
        logic [31:0] e_rdat[2];
        logic        e_ack[2], e_stall[2], e_err[2];
        logic [1:0]  e_grant;
        logic        e_cyc, e_stb, e_we;
        logic [29:0] e_adr;
        logic [3:0]  e_sel;
        logic [31:0] e_wdat;
        logic [140:0] exp_v, got_v;
        int ack_div;
        mc[0] = 0; mc[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            reset_n = (n < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            ack_div = ((n / 250) % 3 == 0) ? 1 : (((n / 250) % 3 == 1) ? 6 : 30);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 5) == 0) mc[k] = ~mc[k];
                mst[k]  = mc[k] & 1'($urandom);
                mwe[k]  = 1'($urandom);
                madr[k] = 30'($urandom);
                mwd[k]  = $urandom;
            end
            bus.m0_cyc = mc[0]; bus.m0_stb = mst[0]; bus.m0_we = mwe[0]; bus.m0_adr = madr[0]; bus.m0_sel = 4'($urandom); bus.m0_wdat = mwd[0];
            bus.m1_cyc = mc[1]; bus.m1_stb = mst[1]; bus.m1_we = mwe[1]; bus.m1_adr = madr[1]; bus.m1_sel = 4'($urandom); bus.m1_wdat = mwd[1];
            bus.s_ack   = ($urandom_range(0, ack_div) == 0);
            bus.s_stall = 1'($urandom);
            bus.s_rdat  = $urandom;
            #1;
            e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_sel = '0; e_wdat = '0; e_grant = 2'b00;
            for (int k = 0; k < 2; k++) begin
                e_rdat[k] = '0; e_ack[k] = 0; e_stall[k] = 1; e_err[k] = 0;
            end
            if (owner >= 0) begin
                e_grant = (owner == 0) ? 2'b01 : 2'b10;
                if (err_now) e_err[owner] = 1;
                if (!dead) begin
                    e_cyc  = mc[owner]; e_stb = mst[owner]; e_we = mwe[owner]; e_adr = madr[owner];
                    e_sel  = (owner == 0) ? bus.m0_sel : bus.m1_sel;
                    e_wdat = mwd[owner];
                    e_rdat[owner] = bus.s_rdat; e_ack[owner] = bus.s_ack; e_stall[owner] = bus.s_stall;
                end
            end
            exp_v = {e_cyc, e_stb, e_we, e_adr, e_sel, e_wdat, e_rdat[0], e_ack[0], e_stall[0], e_err[0],
                     e_rdat[1], e_ack[1], e_stall[1], e_err[1], e_grant};
            got_v = {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_sel, bus.s_wdat,
                     bus.m0_rdat, bus.m0_ack, bus.m0_stall, bus.m0_err,
                     bus.m1_rdat, bus.m1_ack, bus.m1_stall, bus.m1_err, bus.grant};
            if (n >= 1) begin
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL random cycle=%0d got %h want %h", n, got_v, exp_v);
                end
            end
            if (!reset_n) begin
                owner = -1; dead = 0; err_now = 0; quiet = 0; last = 1;
            end else if (owner < 0) begin
                if (mc[0] && mc[1]) owner = 1 - last;
                else if (mc[0]) owner = 0;
                else if (mc[1]) owner = 1;
                quiet = 0;
            end else if (err_now) begin
                err_now = 0;
            end else if (!mc[owner]) begin
                last = owner; owner = -1; dead = 0;
            end else if (!dead) begin
                if (bus.s_ack) quiet = 0;
                else begin
                    quiet++;
                    if (quiet == TO) begin dead = 1; err_now = 1; end
                end
            end
            next_cycle();
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_read_stall();
        test_burst();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
